// File: rtl/pif_wb_pkg.sv
// Shared definitions for the EFB Wishbone arbiter: widths, FSM encoding,
// EFB register map and the bus request bundle.
package pif_wb_pkg;

    localparam int WB_AW         = 8;
    localparam int WB_DW         = 8;
    localparam int TO_CYCLES_DEF = 255;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN0  = 2'd1;
    localparam logic [1:0] ST_OWN1  = 2'd2;
    localparam logic [1:0] ST_ABORT = 2'd3;

    // EFB register map
    localparam logic [WB_AW-1:0] I2C1_CR    = 8'h40;
    localparam logic [WB_AW-1:0] I2C1_CMDR  = 8'h41;
    localparam logic [WB_AW-1:0] I2C1_BR0   = 8'h42;
    localparam logic [WB_AW-1:0] I2C1_BR1   = 8'h43;
    localparam logic [WB_AW-1:0] I2C1_TXDR  = 8'h44;
    localparam logic [WB_AW-1:0] I2C1_SR    = 8'h45;
    localparam logic [WB_AW-1:0] I2C1_GCDR  = 8'h46;
    localparam logic [WB_AW-1:0] I2C1_RXDR  = 8'h47;
    localparam logic [WB_AW-1:0] I2C1_IRQ   = 8'h48;
    localparam logic [WB_AW-1:0] I2C1_IRQEN = 8'h49;
    localparam logic [WB_AW-1:0] I2C2_CR    = 8'h4A;
    localparam logic [WB_AW-1:0] I2C2_CMDR  = 8'h4B;
    localparam logic [WB_AW-1:0] I2C2_BR0   = 8'h4C;
    localparam logic [WB_AW-1:0] I2C2_BR1   = 8'h4D;
    localparam logic [WB_AW-1:0] I2C2_TXDR  = 8'h4E;
    localparam logic [WB_AW-1:0] I2C2_SR    = 8'h4F;
    localparam logic [WB_AW-1:0] I2C2_GCDR  = 8'h50;
    localparam logic [WB_AW-1:0] I2C2_RXDR  = 8'h51;
    localparam logic [WB_AW-1:0] I2C2_IRQ   = 8'h52;
    localparam logic [WB_AW-1:0] I2C2_IRQEN = 8'h53;
    localparam logic [WB_AW-1:0] CFG_CR     = 8'h70;
    localparam logic [WB_AW-1:0] CFG_TXDR   = 8'h71;
    localparam logic [WB_AW-1:0] CFG_SR     = 8'h72;
    localparam logic [WB_AW-1:0] CFG_RXDR   = 8'h73;
    localparam logic [WB_AW-1:0] CFG_IRQ    = 8'h74;
    localparam logic [WB_AW-1:0] CFG_IRQEN  = 8'h75;

    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
    } wbReq_t;

endpackage

// File: rtl/wb_to_cnt.sv
// Strobe stall counter: clear has priority, counts while enabled, flags the
// last permitted stall cycle.
module wb_to_cnt #(
    parameter int TO_CYCLES = 255,
    parameter int TO_W      = $clog2(TO_CYCLES + 1)
) (
    input  logic xclk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge xclk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + TO_W'(1);
    end

    assign tc = (cnt == TO_W'(TO_CYCLES - 1));

endmodule

// File: rtl/efb_wb_arb.sv
// Two-master Wishbone arbiter in front of the EFB slave port: CYC-locked
// ownership, round-robin on contention, ACK-timeout abort.
module efb_wb_arb
    import pif_wb_pkg::*;
#(
    parameter int TO_CYCLES = TO_CYCLES_DEF,
    parameter int TO_W      = $clog2(TO_CYCLES + 1)
) (
    input  logic             xclk,
    input  logic             rst,
    input  logic             m0_cyc,
    input  logic             m0_stb,
    input  logic             m0_we,
    input  logic [WB_AW-1:0] m0_adr,
    input  logic [WB_DW-1:0] m0_dat_i,
    output logic [WB_DW-1:0] m0_dat_o,
    output logic             m0_ack,
    output logic             m0_err,
    input  logic             m1_cyc,
    input  logic             m1_stb,
    input  logic             m1_we,
    input  logic [WB_AW-1:0] m1_adr,
    input  logic [WB_DW-1:0] m1_dat_i,
    output logic [WB_DW-1:0] m1_dat_o,
    output logic             m1_ack,
    output logic             m1_err,
    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [WB_AW-1:0] s_adr,
    output logic [WB_DW-1:0] s_dat_o,
    input  logic [WB_DW-1:0] s_dat_i,
    input  logic             s_ack,
    output logic [1:0]       grant
);

    logic [1:0] state, stateNxt;
    logic       last, lastNxt;
    logic       abrtOwn, abrtOwnNxt;
    logic       own, curOwner, ackOwn, toHit, toTc;
    wbReq_t     req [2];
    wbReq_t     sel;

    assign req[0] = {m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_i};
    assign req[1] = {m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_i};

    // In ABORT the aborted master's cyc is still what releases the bus
    assign own      = (state == ST_OWN0) || (state == ST_OWN1);
    assign curOwner = (state == ST_OWN1) || ((state == ST_ABORT) && abrtOwn);
    assign sel      = req[curOwner];

    assign s_cyc   = own & sel.cyc;
    assign s_stb   = own & sel.stb;
    assign s_we    = own & sel.we;
    assign s_adr   = own ? sel.adr : '0;
    assign s_dat_o = own ? sel.dat : '0;

    assign ackOwn   = own & s_ack;
    assign m0_ack   = ackOwn & ~curOwner;
    assign m1_ack   = ackOwn & curOwner;
    assign m0_dat_o = ackOwn ? s_dat_i : '0;
    assign m1_dat_o = ackOwn ? s_dat_i : '0;

    // ACK on the terminal cycle wins over the timeout
    assign toHit  = own & sel.stb & toTc & ~s_ack;
    assign m0_err = toHit & ~curOwner;
    assign m1_err = toHit & curOwner;

    assign grant = (state == ST_IDLE) ? 2'b00 : (curOwner ? 2'b10 : 2'b01);

    wb_to_cnt #(
        .TO_CYCLES(TO_CYCLES),
        .TO_W     (TO_W)
    ) uToCnt (
        .xclk(xclk),
        .rst (rst),
        .clr (~own | ~sel.stb | s_ack),
        .en  (own & sel.stb),
        .tc  (toTc)
    );

    always_comb begin
        stateNxt   = state;
        lastNxt    = last;
        abrtOwnNxt = abrtOwn;
        case (state)
            ST_IDLE: begin
                if (m0_cyc && (!m1_cyc || last))
                    stateNxt = ST_OWN0;
                else if (m1_cyc)
                    stateNxt = ST_OWN1;
            end
            ST_OWN0, ST_OWN1: begin
                if (!sel.cyc) begin
                    stateNxt = ST_IDLE;
                    lastNxt  = curOwner;
                end else if (toHit) begin
                    stateNxt   = ST_ABORT;
                    abrtOwnNxt = curOwner;
                end
            end
            ST_ABORT: begin
                if (!sel.cyc) begin
                    stateNxt = ST_IDLE;
                    lastNxt  = abrtOwn;
                end
            end
            default: stateNxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge xclk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            last    <= 1'b1;
            abrtOwn <= 1'b0;
        end else begin
            state   <= stateNxt;
            last    <= lastNxt;
            abrtOwn <= abrtOwnNxt;
        end
    end

endmodule

// File: tb/tb_efb_wb_arb.sv
// Scoreboard bench for efb_wb_arb: per-master expected-response queues,
// an EFB responder with planned latency, directed and random traffic.
module tb_efb_wb_arb;
    import pif_wb_pkg::*;

    localparam int TO = 4;

    typedef struct { logic isErr; logic [7:0] dat; } exp_t;
    typedef struct { logic we; logic [7:0] adr; logic [7:0] dat; logic [7:0] rd; int d; } plan_t;

    logic       xclk = 1'b0;
    logic       rst  = 1'b1;
    logic       mCyc [2];
    logic       mStb [2];
    logic       mWe  [2];
    logic [7:0] mAdr [2];
    logic [7:0] mDatI[2];
    logic [7:0] m0_dat_o, m1_dat_o;
    logic       m0_ack, m1_ack, m0_err, m1_err;
    logic       s_cyc, s_stb, s_we;
    logic [7:0] s_adr, s_dat_o;
    logic [7:0] sDatI;
    logic       sAck;
    logic [1:0] grant;

    exp_t       expQ0[$];
    exp_t       expQ1[$];
    plan_t      plan[2];
    logic [1:0] gSeq[$];
    logic [1:0] gPrev = 2'b00;
    int         nCmp = 0;
    int         nBad = 0;
    int         sCnt = 0;

    efb_wb_arb #(.TO_CYCLES(TO)) dut (
        .xclk(xclk), .rst(rst),
        .m0_cyc(mCyc[0]), .m0_stb(mStb[0]), .m0_we(mWe[0]), .m0_adr(mAdr[0]),
        .m0_dat_i(mDatI[0]), .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(mCyc[1]), .m1_stb(mStb[1]), .m1_we(mWe[1]), .m1_adr(mAdr[1]),
        .m1_dat_i(mDatI[1]), .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
        .s_dat_i(sDatI), .s_ack(sAck), .grant(grant)
    );

    always #5 xclk = ~xclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        nCmp++;
        if (act !== want) begin
            nBad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    function automatic logic ackOf(input int n);
        return (n == 1) ? m1_ack : m0_ack;
    endfunction

    function automatic logic errOf(input int n);
        return (n == 1) ? m1_err : m0_err;
    endfunction

    task automatic pushExp(input int n, input exp_t x);
        if (n == 1) expQ1.push_back(x); else expQ0.push_back(x);
    endtask

    // Response monitor: every ack/err pops the owner's expected outcome
    always @(negedge xclk) begin
        exp_t x;
        logic a, e;
        logic [7:0] d;
        chk("grantOnehot", 64'(grant == 2'b11), 64'd0);
        for (int n = 0; n < 2; n++) begin
            a = ackOf(n);
            e = errOf(n);
            d = (n == 1) ? m1_dat_o : m0_dat_o;
            if (a || e) begin
                chk("respOwner", 64'(grant), (n == 1) ? 64'd2 : 64'd1);
                if ((n == 1) ? (expQ1.size() == 0) : (expQ0.size() == 0)) begin
                    nCmp++;
                    nBad++;
                    $display("FAIL unexpectedResp m%0d: got ack=%0b err=%0b, want none", n, a, e);
                end else begin
                    x = (n == 1) ? expQ1.pop_front() : expQ0.pop_front();
                    chk("errFlag", 64'(e), 64'(x.isErr));
                    chk("ackFlag", 64'(a), 64'(!x.isErr));
                    if (!x.isErr) chk("rdData", 64'(d), 64'(x.dat));
                end
            end
        end
        if (grant != gPrev && grant != 2'b00) gSeq.push_back(grant);
        gPrev = grant;
    end

    // EFB responder: acks the owner's strobe after plan.d stall cycles
    initial begin
        int o;
        sAck  = 1'b0;
        sDatI = 8'h00;
        forever begin
            @(posedge xclk);
            #3;
            sAck  = 1'b0;
            sDatI = 8'h00;
            if (s_stb) begin
                if (grant == 2'b01 || grant == 2'b10) begin
                    o = (grant == 2'b10) ? 1 : 0;
                    if (sCnt == 0) begin
                        chk("fwdAdr", 64'(s_adr), 64'(plan[o].adr));
                        chk("fwdWe", 64'(s_we), 64'(plan[o].we));
                        if (plan[o].we) chk("fwdDat", 64'(s_dat_o), 64'(plan[o].dat));
                    end
                    if (sCnt == plan[o].d) begin
                        sAck  = 1'b1;
                        sDatI = plan[o].rd;
                        sCnt  = 0;
                    end else begin
                        sCnt++;
                    end
                end else begin
                    nCmp++;
                    nBad++;
                    $display("FAIL stbNoGrant: got grant=%0b with s_stb=1, want one-hot", grant);
                end
            end else begin
                sCnt = 0;
            end
        end
    end

    task automatic setReq(input int n, input logic we, input logic [7:0] adr, input logic [7:0] dat,
                          input int d, input logic [7:0] rd);
        plan[n].we  = we;
        plan[n].adr = adr;
        plan[n].dat = dat;
        plan[n].d   = d;
        plan[n].rd  = rd;
        mCyc[n]  = 1'b1;
        mStb[n]  = 1'b1;
        mWe[n]   = we;
        mAdr[n]  = adr;
        mDatI[n] = dat;
    endtask

    task automatic clrStb(input int n);
        mStb[n]  = 1'b0;
        mWe[n]   = 1'b0;
        mAdr[n]  = 8'h00;
        mDatI[n] = 8'h00;
    endtask

    // One strobe; the expected outcome follows from the planned EFB latency
    task automatic doStrobe(input int n, input logic we, input logic [7:0] adr, input logic [7:0] dat,
                            input int d, input logic [7:0] rd, output logic gotErr);
        exp_t x;
        logic done;
        x.isErr = (d >= TO);
        x.dat   = rd;
        pushExp(n, x);
        @(posedge xclk);
        #1;
        setReq(n, we, adr, dat, d, rd);
        gotErr = 1'b0;
        done   = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge xclk);
            if (ackOf(n) || errOf(n)) begin
                done   = 1'b1;
                gotErr = errOf(n);
            end
        end
        if (!done) begin
            nCmp++;
            nBad++;
            $display("FAIL strobeTimeout m%0d: got no ack/err in 200 cycles, want response", n);
        end
        @(posedge xclk);
        #1;
        clrStb(n);
    endtask

    task automatic endCyc(input int n);
        @(posedge xclk);
        #1;
        mCyc[n] = 1'b0;
    endtask

    task automatic chkAllZero(input string nm);
        chk({nm, "_bus"}, 64'({s_cyc, s_stb, s_we, s_adr, s_dat_o, grant}), 64'd0);
        chk({nm, "_mst"}, 64'({m0_ack, m1_ack, m0_err, m1_err, m0_dat_o, m1_dat_o}), 64'd0);
    endtask

    task automatic randMaster(input int n, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            int   ns;
            logic e;
            ns = int'($urandom_range(1, 3));
            e  = 1'b0;
            for (int s = 0; s < ns && !e; s++)
                doStrobe(n, 1'($urandom_range(0, 1)), 8'($urandom_range(8'h40, 8'h75)),
                         8'($urandom), int'($urandom_range(0, TO + 1)), 8'($urandom), e);
            endCyc(n);
            repeat (int'($urandom_range(0, 3))) @(posedge xclk);
        end
    endtask

    task automatic singleLoop(input int n);
        logic e;
        for (int i = 0; i < 3; i++) begin
            doStrobe(n, 1'b0, CFG_SR, 8'h00, 0, 8'(8'h10 + i + 16 * n), e);
            endCyc(n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e;
        for (int n = 0; n < 2; n++) begin
            mCyc[n] = 1'b0;
            clrStb(n);
            plan[n].we = 1'b0; plan[n].adr = 8'h00; plan[n].dat = 8'h00;
            plan[n].rd = 8'h00; plan[n].d = 0;
        end

        // Reset state
        repeat (2) @(negedge xclk);
        chkAllZero("reset");
        @(posedge xclk); #1 rst = 1'b0;

        // m0 reads I2C1_SR, EFB acks after 2 stall cycles with 0x44
        @(posedge xclk); #1 mCyc[0] = 1'b1;
        @(negedge xclk); chk("latIdle", 64'({s_cyc, grant}), 64'd0);
        @(negedge xclk); chk("latGrant", 64'({s_cyc, grant}), 64'b101);
        doStrobe(0, 1'b0, I2C1_SR, 8'h00, 2, 8'h44, e);
        endCyc(0);
        repeat (2) @(posedge xclk);

        // Contention straight after reset, then one dead cycle before m1
        #1 rst = 1'b1;
        @(posedge xclk); #1 rst = 1'b0;
        @(posedge xclk); #1 mCyc[0] = 1'b1; mCyc[1] = 1'b1;
        @(negedge xclk); chk("contIdle", 64'(grant), 64'd0);
        @(negedge xclk); chk("contFirst", 64'(grant), 64'd1);
        doStrobe(0, 1'b0, I2C1_RXDR, 8'h00, 0, 8'h3C, e);
        endCyc(0);
        @(negedge xclk); chk("relDrop", 64'(grant), 64'd1);
        @(negedge xclk); chk("relDead", 64'(grant), 64'd0);
        @(negedge xclk); chk("relNext", 64'(grant), 64'd2);
        doStrobe(1, 1'b1, CFG_CR, 8'h80, 1, 8'h00, e);
        endCyc(1);
        repeat (2) @(posedge xclk);

        // Continuous single-strobe requests alternate
        gSeq.delete();
        fork
            singleLoop(0);
            singleLoop(1);
        join
        chk("altCount", 64'(gSeq.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < gSeq.size(); i++)
            chk("altSeq", 64'(gSeq[i]), (i % 2 == 1) ? 64'd2 : 64'd1);
        repeat (2) @(posedge xclk);

        // Timeout on m1 while m0 waits
        begin
            exp_t x;
            x.isErr = 1'b1;
            x.dat   = 8'h00;
            pushExp(1, x);
        end
        @(posedge xclk); #1 setReq(1, 1'b1, CFG_TXDR, 8'h5A, 1000, 8'h00);
        @(negedge xclk); chk("toIdle", 64'(grant), 64'd0);
        for (int k = 1; k <= TO; k++) begin
            @(negedge xclk);
            chk("toStall", 64'(s_stb), 64'd1);
            chk("toErr", 64'(m1_err), 64'(k == TO));
            if (k == 1) mCyc[0] = 1'b1;
        end
        @(negedge xclk);
        chk("abStb", 64'(s_stb), 64'd0);
        chk("abGrant", 64'(grant), 64'd2);
        chk("abErrPulse", 64'(m1_err), 64'd0);
        @(negedge xclk); chk("abHold", 64'({s_cyc, grant}), 64'd2);
        @(posedge xclk); #1 mCyc[1] = 1'b0; clrStb(1);
        @(negedge xclk); chk("abRelease", 64'(grant), 64'd2);
        @(negedge xclk); chk("abDead", 64'(grant), 64'd0);
        @(negedge xclk); chk("abNext", 64'(grant), 64'd1);
        doStrobe(0, 1'b0, CFG_RXDR, 8'h00, 1, 8'hE7, e);
        endCyc(0);
        repeat (2) @(posedge xclk);

        // ACK coincides with terminal count
        doStrobe(1, 1'b0, CFG_IRQ, 8'h00, TO - 1, 8'hC3, e);
        chk("tcAckNoErr", 64'(e), 64'd0);
        endCyc(1);
        repeat (2) @(posedge xclk);

        // Asynchronous reset mid-transfer; m0 owned last, reset restores m0 priority
        doStrobe(0, 1'b0, I2C2_SR, 8'h00, 0, 8'h21, e);
        endCyc(0);
        repeat (2) @(posedge xclk);
        #1 setReq(0, 1'b0, I2C1_SR, 8'h00, 1000, 8'h00);
        @(negedge xclk);
        @(negedge xclk); chk("preRstStb", 64'(s_stb), 64'd1);
        #2 rst = 1'b1;
        #1 chkAllZero("asyncRst");
        @(posedge xclk); #1 mCyc[0] = 1'b0; clrStb(0);
        @(posedge xclk); #1 rst = 1'b0;
        @(posedge xclk); #1 mCyc[0] = 1'b1; mCyc[1] = 1'b1;
        @(negedge xclk); chk("postRstIdle", 64'(grant), 64'd0);
        @(negedge xclk); chk("postRstGrant", 64'(grant), 64'd1);
        @(posedge xclk); #1 mCyc[0] = 1'b0; mCyc[1] = 1'b0;
        repeat (3) @(posedge xclk);

        // Random concurrent traffic
        fork
            randMaster(0, 40);
            randMaster(1, 40);
        join
        repeat (5) @(posedge xclk);
        chk("q0Drained", 64'(expQ0.size()), 64'd0);
        chk("q1Drained", 64'(expQ1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/efb_wb_arb.md
# efb_wb_arb

Two-master Wishbone arbiter sharing the single EFB Wishbone slave port between the I2C slave sequencer (m0) and the configuration/flash controller (m1). Grants whole bus cycles (CYC-locked, multi-strobe), arbitrates round-robin on contention, and aborts a stalled transfer with an error pulse when the EFB fails to ACK within a programmable bound. Sits between the masters and the EFB instance, on the same clock as both.

## Interface
- TO_CYCLES, 255: max cycles a strobe may wait for ACK before abort; 1..65535.
- TO_W, $clog2(TO_CYCLES+1): timeout counter width (derived).
- xclk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- mN_cyc, mN_stb, mN_we  in  1 each  master N (N=0,1) cycle/strobe/write.
- mN_adr  in  8  master N EFB address.
- mN_dat_i  in  8  master N write data.
- mN_dat_o  out  8  read data to master N.
- mN_ack  out  1  ACK to master N.
- mN_err  out  1  one-cycle abort pulse to master N.
- s_cyc, s_stb, s_we  out  1 each  to EFB.
- s_adr  out  8  to EFB.
- s_dat_o  out  8  write data to EFB.
- s_dat_i  in  8  read data from EFB.
- s_ack  in  1  ACK from EFB.
- grant  out  2  one-hot current owner; 00 when none.

## Operation
- States: IDLE, OWN0, OWN1, ABORT. Register `last` (last owner), reset value 1 so m0 wins first contention.
- IDLE: only m0_cyc → OWN0; only m1_cyc → OWN1; both → owner = !last. Neither → stay.
- OWNn: s_cyc/s_stb/s_we/s_adr/s_dat_o = master n's signals; mN_ack = s_ack only for n; mN_dat_o = s_dat_i for both masters (qualified by ack). Non-owner sees ack=0, err=0.
- OWNn held while mn_cyc=1, across any number of strobes. mn_cyc=0 → IDLE, last<=n.
- Timeout counter: cleared when not OWNn, when s_stb=0, or when s_ack=1; otherwise increments. Counter == TO_CYCLES-1 with s_ack=0 → mn_err=1 for that cycle, next state ABORT.
- ABORT: s_cyc=s_stb=s_we=0, grant kept; wait for aborted master's cyc=0 → IDLE, last<=n.
- IDLE/ABORT: s_cyc, s_stb, s_we = 0; s_adr, s_dat_o = 0.

## Timing
- Reset (asynchronous, immediate): state IDLE, last=1, counter 0; all outputs 0 (s_*, mN_ack, mN_err, mN_dat_o, grant).
- Grant latency: mN_cyc sampled in IDLE → s_cyc visible next cycle. Master must hold stb/adr/data until ack (standard classic Wishbone).
- Within ownership, forwarding is combinational: s_stb follows mn_stb same cycle, s_ack → mn_ack same cycle.
- Release: owner drops cyc in cycle t → IDLE at t+1 → new grant visible at t+2; exactly one dead cycle between owners, also when the other master raised cyc in cycle t.
- ACK and timeout in the same cycle: ACK wins, no err, counter clears.
- Timeout: err asserted in the TO_CYCLES-th consecutive stalled cycle of a strobe; s_stb drops the following cycle.
- Owner raising cyc again the cycle after release while the other master idles: re-granted (round-robin affects contention only).
- err never asserted outside OWNn; ack never asserted in IDLE/ABORT even if s_ack glitches high.

## Structure
- Shared package pif_wb_pkg: state encoding, EFB register address constants (I2C1_*, I2C2_*, CFG_* at 0x40..0x75), default TO_CYCLES, 8-bit address/data widths.
- One sub-module: wb_to_cnt (clear/enable/terminal-count counter parameterised by TO_CYCLES); arbiter FSM and muxing stay in efb_wb_arb.

## Test plan
- m0 reads 0x45 (I2C1_SR), EFB acks after 2 cycles with 0x44 → s_cyc one cycle after m0_cyc, m0_ack with m0_dat_o=0x44, m1_ack stays 0, grant=01.
- m0 and m1 raise cyc same cycle from reset → m0 granted; m0 drops cyc → one IDLE cycle, then grant=10 with m1 write 0x70←0x80 forwarded.
- Both request continuously with single-strobe cycles → grants alternate 01,10,01,10.
- TO_CYCLES=4, EFB never acks m1 strobe → m1_err in 4th stall cycle, s_stb=0 next cycle, state ABORT until m1_cyc=0, then m0 pending request granted.
- EFB acks in the same cycle the counter reaches terminal count → ack delivered, no err, transfer completes.
- rst asserted mid-transfer (OWN0, s_stb=1) → all outputs 0 without waiting for a clock edge; after release, first contention grants m0.
